// File: rtl/audio_peak_meter.sv
// Audio peak meter: per-window peak magnitude with peak-hold and halving decay,
// producing an 8-bit level word for the LED bar-graph stage.
module audio_peak_meter #(
    parameter int unsigned SAMPLE_W       = 16,
    parameter int unsigned WINDOW_SAMPLES = 1024,
    parameter int unsigned HOLD_WINDOWS   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    output logic [7:0]                 level_out,
    output logic                       level_valid
);

    localparam int unsigned MAG_W  = SAMPLE_W - 1;
    localparam int unsigned CNT_W  = (WINDOW_SAMPLES > 1) ? $clog2(WINDOW_SAMPLES) : 1;
    localparam int unsigned HOLD_W = (HOLD_WINDOWS > 0) ? $clog2(HOLD_WINDOWS + 1) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WINDOW_SAMPLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_WINDOWS);

    logic [MAG_W-1:0]  peak;
    logic [CNT_W-1:0]  count;
    logic [HOLD_W-1:0] hold;

    logic [MAG_W-1:0]  peak_n;
    logic [CNT_W-1:0]  count_n;
    logic [HOLD_W-1:0] hold_n;
    logic [7:0]        level_n;
    logic              valid_n;

    logic [MAG_W-1:0]  mag_c;
    logic [MAG_W-1:0]  merged_c;
    logic [7:0]        win_c;
    logic [7:0]        decay_c;
    logic              accept_c;
    logic              close_c;

    // Magnitude of the incoming sample; the most negative code saturates to all-ones.
    always_comb begin
        mag_c = sample_in[MAG_W-1:0];
        if (sample_in[SAMPLE_W-1]) begin
            if (sample_in[MAG_W-1:0] == '0) begin
                mag_c = '1;
            end else begin
                mag_c = ~sample_in[MAG_W-1:0] + MAG_W'(1);
            end
        end
    end

    // Window peak including the current sample, its level byte and the decayed level.
    always_comb begin
        merged_c = (mag_c > peak) ? mag_c : peak;
        win_c    = merged_c[MAG_W-1 -: 8];
        decay_c  = (win_c > (level_out >> 1)) ? win_c : (level_out >> 1);
        accept_c = sample_valid & enable;
        close_c  = accept_c & (count == CNT_LAST);
    end

    // Next-state: window accumulation and hold/decay display update at window close.
    always_comb begin
        peak_n  = peak;
        count_n = count;
        hold_n  = hold;
        level_n = level_out;
        valid_n = 1'b0;
        if (accept_c) begin
            if (close_c) begin
                count_n = '0;
                peak_n  = '0;
                valid_n = 1'b1;
                if (win_c >= level_out) begin
                    level_n = win_c;
                    hold_n  = HOLD_INIT;
                end else if (hold != '0) begin
                    hold_n = hold - HOLD_W'(1);
                end else begin
                    level_n = decay_c;
                end
            end else begin
                count_n = count + CNT_W'(1);
                peak_n  = merged_c;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak        <= '0;
            count       <= '0;
            hold        <= '0;
            level_out   <= '0;
            level_valid <= 1'b0;
        end else begin
            peak        <= peak_n;
            count       <= count_n;
            hold        <= hold_n;
            level_out   <= level_n;
            level_valid <= valid_n;
        end
    end

endmodule
